fuzzy_rule_inference: RTL and testbench
=======================================

Name: fuzzy_rule_inference

Overview:
- Inference stage directly downstream of Fuzzification.
- Consumes one membership-degree vector for Error and one for ErrorChange.
- Evaluates the full pNoOfMembers x pNoOfMembers rule base sequentially, one rule per clock, using Mamdani min/max.
- Produces one aggregated degree per output fuzzy set for the defuzzifier.

Parameters:
- pFuzzyWidth, 3, width of one membership degree (0 = none, 2^pFuzzyWidth-1 = full).
- pNoOfMembers, 7, number of fuzzy sets per variable. Index 0=PL, 1=PM, 2=PS, 3=Z, 4=NS, 5=NM, 6=NL.
- pIndexWidth, 3, width of one rule consequent index. Must satisfy 2^pIndexWidth > pNoOfMembers.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- InValid  input  1  start request. Accepted only when Busy=0.
- ErrorDegrees  input  pFuzzyWidth*pNoOfMembers  Error degree per set; set k occupies bits [pFuzzyWidth*(k+1)-1 : pFuzzyWidth*k].
- ErrorChangeDegrees  input  pFuzzyWidth*pNoOfMembers  ErrorChange degree per set; same packing.
- RuleTable  input  pIndexWidth*pNoOfMembers*pNoOfMembers  consequent set index for rule r = i*pNoOfMembers+j (i = Error set, j = ErrorChange set); occupies bits [pIndexWidth*(r+1)-1 : pIndexWidth*r].
- Busy  output  1  high while a rule base evaluation is in progress.
- ValidOut  output  1  single-cycle pulse: OutputDegrees updated.
- OutputDegrees  output  pFuzzyWidth*pNoOfMembers  aggregated degree per output set; same packing as ErrorDegrees.

Behaviour:
- Reset (async, active-high): FSM to IDLE; Busy=0, ValidOut=0, OutputDegrees=0; internal accumulators and rule counter cleared.
- FSM states: IDLE, EVAL, DONE.
  - IDLE: when InValid=1, capture ErrorDegrees, ErrorChangeDegrees and RuleTable into internal registers; clear all accumulators; rule counter r=0; go to EVAL. Busy=1 from the next cycle.
  - EVAL: one rule per cycle, r = 0 .. pNoOfMembers^2-1 (49 cycles by default).
    - strength = min(E[i], dE[j]), unsigned compare.
    - k = captured RuleTable[r].
    - If k < pNoOfMembers: acc[k] <= max(acc[k], strength).
    - If k >= pNoOfMembers (e.g. 7): rule disabled, no update.
    - After the last rule, go to DONE.
  - DONE: OutputDegrees <= acc; ValidOut=1 for exactly this cycle; Busy=0 in this cycle; next state IDLE.
- Latency: InValid sampled high at edge 0 gives ValidOut high in the cycle after edge 50 (pNoOfMembers^2+1 edges). The latency is fixed and independent of the data.
- Throughput: a new InValid is accepted in the cycle immediately after the ValidOut cycle.
- Inputs are sampled only at acceptance. Changes to the inputs while Busy=1 have no effect.
- InValid while Busy=1: ignored. No queueing, no error flag.
- Degrees saturate naturally: min/max never exceed 2^pFuzzyWidth-1, so no overflow handling is required.
- OutputDegrees holds its value between ValidOut pulses and changes only in the DONE cycle.
- Reset mid-EVAL: evaluation is abandoned and everything is cleared as above. No ValidOut is produced for the aborted request.
- Ties in min/max: equal values give that value; no priority is involved.

Test Plan:
- All degrees 0, any table, InValid pulse → Busy high 49 cycles; ValidOut at edge 50; OutputDegrees=0.
- E[3]=5, dE[3]=7, others 0; rule 24 → 3, all others → 7 (disabled) → OutputDegrees set 3 = 5, all others 0; ValidOut exactly one cycle.
- E[0]=3, E[1]=6, dE[0]=7; rules 0 and 7 both → 2 → set 2 = max(min(3,7), min(6,7)) = 6.
- Identity-diagonal table (rule i*7+i → i, others → 7), E = dE = {1,2,3,4,5,6,7} → OutputDegrees = {1,2,3,4,5,6,7}. Then change the inputs while Busy is high → no effect on the result.
- InValid held high continuously → ValidOut every 51 cycles. A second InValid at cycle 20 of a run is ignored.
- Reset asserted at cycle 20 of EVAL → Busy, ValidOut, OutputDegrees go to 0 asynchronously. A subsequent InValid completes normally with the correct result.

Source files
------------

// File: rtl/fuzzy_rule_inference.sv
// fuzzy_rule_inference
//   Mamdani min/max inference stage that sits after fuzzification. One accepted
//   request evaluates the whole pNoOfMembers x pNoOfMembers rule base, one rule
//   per clock. It then publishes one aggregated degree per output fuzzy set.
//
// Ports
//   Clock, Reset         rising-edge clock, asynchronous active-high reset
//   InValid              start request, accepted only while idle
//   ErrorDegrees         Error degree per set, set k at [W*(k+1)-1 : W*k]
//   ErrorChangeDegrees   ErrorChange degree per set, same packing
//   RuleTable            consequent index of rule r = i*N+j, at [IW*(r+1)-1 : IW*r]
//   Busy                 high while the rule base is being walked
//   ValidOut             one-cycle pulse when OutputDegrees is updated
//   OutputDegrees        aggregated degree per output set, same packing as inputs
module fuzzy_rule_inference #(
    parameter int pFuzzyWidth  = 3,
    parameter int pNoOfMembers = 7,
    parameter int pIndexWidth  = 3
) (
    input  logic                                        Clock,
    input  logic                                        Reset,
    input  logic                                        InValid,
    input  logic [pFuzzyWidth*pNoOfMembers-1:0]         ErrorDegrees,
    input  logic [pFuzzyWidth*pNoOfMembers-1:0]         ErrorChangeDegrees,
    input  logic [pIndexWidth*pNoOfMembers*pNoOfMembers-1:0] RuleTable,
    output logic                                        Busy,
    output logic                                        ValidOut,
    output logic [pFuzzyWidth*pNoOfMembers-1:0]         OutputDegrees
);

    localparam int N  = pNoOfMembers;
    localparam int NR = N * N;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int RW = (NR > 1) ? $clog2(NR) : 1;
    localparam logic [RW-1:0] LAST_RULE = RW'(NR - 1);
    localparam logic [CW-1:0] LAST_SET  = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

    state_t state, state_nxt;

    logic [pFuzzyWidth*N-1:0]      e_q, de_q;
    logic [pIndexWidth*NR-1:0]     rule_q;
    logic [CW-1:0]                 i_cnt, j_cnt;
    logic [RW-1:0]                 r_cnt;
    logic [N-1:0][pFuzzyWidth-1:0] acc;

    logic [pFuzzyWidth-1:0] e_arr  [N];
    logic [pFuzzyWidth-1:0] de_arr [N];
    logic [pIndexWidth-1:0] rule_arr [NR];

    logic [pFuzzyWidth-1:0] e_cur, de_cur, strength;
    logic [pIndexWidth-1:0] k;
    logic                   accept, last;

    for (genvar s = 0; s < N; s++) begin : g_unpack_deg
        assign e_arr[s]  = e_q[pFuzzyWidth*s +: pFuzzyWidth];
        assign de_arr[s] = de_q[pFuzzyWidth*s +: pFuzzyWidth];
    end
    for (genvar r = 0; r < NR; r++) begin : g_unpack_rule
        assign rule_arr[r] = rule_q[pIndexWidth*r +: pIndexWidth];
    end

    // i/j walk the rule grid alongside r, so the captured degree vectors can
    // be indexed without a divider.
    assign e_cur    = e_arr[i_cnt];
    assign de_cur   = de_arr[j_cnt];
    assign strength = (e_cur < de_cur) ? e_cur : de_cur;
    assign k        = rule_arr[r_cnt];
    assign accept   = (state == IDLE) && InValid;
    assign last     = (r_cnt == LAST_RULE);

    // State register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (InValid) state_nxt = EVAL;
            EVAL:    if (last)    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        Busy = (state == EVAL);
    end

    // Datapath: capture, rule walk, aggregation, publish
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            e_q           <= '0;
            de_q          <= '0;
            rule_q        <= '0;
            i_cnt         <= '0;
            j_cnt         <= '0;
            r_cnt         <= '0;
            acc           <= '0;
            ValidOut      <= 1'b0;
            OutputDegrees <= '0;
        end else begin
            ValidOut <= (state == DONE);
            if (state == DONE) OutputDegrees <= acc;

            if (accept) begin
                e_q    <= ErrorDegrees;
                de_q   <= ErrorChangeDegrees;
                rule_q <= RuleTable;
                i_cnt  <= '0;
                j_cnt  <= '0;
                r_cnt  <= '0;
                acc    <= '0;
            end else if (state == EVAL) begin
                r_cnt <= r_cnt + RW'(1);
                if (j_cnt == LAST_SET) begin
                    j_cnt <= '0;
                    i_cnt <= i_cnt + CW'(1);
                end else begin
                    j_cnt <= j_cnt + CW'(1);
                end
                // A consequent index >= N matches no set, which disables the rule.
                for (int s = 0; s < N; s++) begin
                    if (k == pIndexWidth'(s) && strength > acc[s])
                        acc[s] <= strength;
                end
            end
        end
    end

endmodule

// File: tb/tb_fuzzy_rule_inference.sv
module tb_fuzzy_rule_inference;

    localparam int W  = 3;
    localparam int N  = 7;
    localparam int IW = 3;
    localparam int DW = W * N;
    localparam int TW = IW * N * N;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          InValid = 1'b0;
    logic [DW-1:0] ErrorDegrees = '0;
    logic [DW-1:0] ErrorChangeDegrees = '0;
    logic [TW-1:0] RuleTable = '0;
    logic          Busy;
    logic          ValidOut;
    logic [DW-1:0] OutputDegrees;

    fuzzy_rule_inference #(
        .pFuzzyWidth(W), .pNoOfMembers(N), .pIndexWidth(IW)
    ) dut (
        .Clock(Clock), .Reset(Reset), .InValid(InValid),
        .ErrorDegrees(ErrorDegrees), .ErrorChangeDegrees(ErrorChangeDegrees),
        .RuleTable(RuleTable), .Busy(Busy), .ValidOut(ValidOut),
        .OutputDegrees(OutputDegrees)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        string         name;
        logic [DW-1:0] e;
        logic [DW-1:0] de;
        logic [TW-1:0] rt;
        logic [DW-1:0] exp;
        bit            scramble;
        bit            poke;
    } vec_t;

    vec_t vecs[6];
    int   tests = 0;
    int   fails = 0;

    function automatic logic [DW-1:0] pk(int d0, int d1, int d2, int d3, int d4, int d5, int d6);
        return {3'(d6), 3'(d5), 3'(d4), 3'(d3), 3'(d2), 3'(d1), 3'(d0)};
    endfunction

    function automatic logic [TW-1:0] fill(int kk);
        logic [TW-1:0] t;
        t = '0;
        for (int r = 0; r < N * N; r++) t[r*IW +: IW] = 3'(kk);
        return t;
    endfunction

    function automatic logic [TW-1:0] set_rule(logic [TW-1:0] t, int r, int kk);
        t[r*IW +: IW] = 3'(kk);
        return t;
    endfunction

    function automatic logic [TW-1:0] diag();
        logic [TW-1:0] t;
        t = fill(7);
        for (int i = 0; i < N; i++) t = set_rule(t, i * N + i, i);
        return t;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Apply one vector and observe 60 cycles after the accepting edge (edge 0).
    task automatic run_vec(input vec_t v);
        int busy_cnt, vo_cnt, vo_at;
        bit hold_ok;
        logic [DW-1:0] prev;
        @(posedge Clock); #1;
        ErrorDegrees = v.e;
        ErrorChangeDegrees = v.de;
        RuleTable = v.rt;
        InValid = 1'b1;
        prev = OutputDegrees;
        @(posedge Clock); #1;
        InValid = 1'b0;
        busy_cnt = 0; vo_cnt = 0; vo_at = -1; hold_ok = 1'b1;
        for (int n = 0; n <= 60; n++) begin
            if (n > 0) begin
                @(posedge Clock); #1;
            end
            if (Busy) busy_cnt++;
            if (ValidOut) begin
                vo_cnt++;
                if (vo_at < 0) vo_at = n;
            end
            if (!ValidOut && vo_cnt == 0 && OutputDegrees !== prev) hold_ok = 1'b0;
            if (v.scramble && n == 10) begin
                ErrorDegrees       = DW'($urandom());
                ErrorChangeDegrees = DW'($urandom());
                RuleTable          = fill(0);
            end
            if (v.poke && n == 20) InValid = 1'b1;
            if (v.poke && n == 21) InValid = 1'b0;
        end
        chk({v.name, " busy_cycles"}, 64'(busy_cnt), 64'd49);
        chk({v.name, " valid_edge"}, 64'(vo_at), 64'd50);
        chk({v.name, " valid_pulses"}, 64'(vo_cnt), 64'd1);
        chk({v.name, " out_hold"}, 64'(hold_ok), 64'd1);
        chk({v.name, " out"}, 64'(OutputDegrees), 64'(v.exp));
    endtask

    initial begin
        int t1, t2, vo_seen;

        vecs[0] = '{"zero",  '0, '0, diag(), '0, 1'b0, 1'b0};
        vecs[1] = '{"single", pk(0,0,0,5,0,0,0), pk(0,0,0,7,0,0,0),
                    set_rule(fill(7), 24, 3), pk(0,0,0,5,0,0,0), 1'b0, 1'b0};
        vecs[2] = '{"max2",  pk(3,6,0,0,0,0,0), pk(7,0,0,0,0,0,0),
                    set_rule(set_rule(fill(7), 0, 2), 7, 2), pk(0,0,6,0,0,0,0), 1'b0, 1'b0};
        vecs[3] = '{"diag",  pk(1,2,3,4,5,6,7), pk(1,2,3,4,5,6,7),
                    diag(), pk(1,2,3,4,5,6,7), 1'b1, 1'b1};
        vecs[4] = '{"all0",  pk(7,7,7,7,7,7,7), pk(4,2,4,1,3,4,0),
                    fill(0), pk(4,0,0,0,0,0,0), 1'b0, 1'b0};
        // rule 6 (i0,j6)->6 gives min(5,6)=5; rule 48 (last)->5 gives min(7,6)=6;
        // rule 42 (i6,j0)->6 gives min(7,0)=0 and must not lower set 6.
        vecs[5] = '{"edges", pk(5,0,0,0,0,0,7), pk(0,0,0,0,0,0,6),
                    set_rule(set_rule(set_rule(fill(7), 6, 6), 48, 5), 42, 6),
                    pk(0,0,0,0,0,6,5), 1'b0, 1'b0};

        // Reset state
        repeat (3) @(posedge Clock);
        #1;
        Reset = 1'b0;
        #1;
        chk("reset busy", 64'(Busy), 64'd0);
        chk("reset valid", 64'(ValidOut), 64'd0);
        chk("reset out", 64'(OutputDegrees), 64'd0);

        for (int v = 0; v < 6; v++) run_vec(vecs[v]);

        // InValid held high: back-to-back runs every 51 cycles
        @(posedge Clock); #1;
        ErrorDegrees = vecs[3].e;
        ErrorChangeDegrees = vecs[3].de;
        RuleTable = vecs[3].rt;
        InValid = 1'b1;
        t1 = -1; t2 = -1;
        for (int n = 0; n <= 160 && t2 < 0; n++) begin
            @(posedge Clock); #1;
            if (ValidOut) begin
                if (t1 < 0) t1 = n;
                else        t2 = n;
            end
        end
        InValid = 1'b0;
        chk("cont first_valid", 64'(t1), 64'd50);
        chk("cont period", 64'(t2 - t1), 64'd51);
        chk("cont out", 64'(OutputDegrees), 64'(vecs[3].exp));
        repeat (60) @(posedge Clock);

        // Reset in the middle of EVAL
        @(posedge Clock); #1;
        ErrorDegrees = vecs[1].e;
        ErrorChangeDegrees = vecs[1].de;
        RuleTable = vecs[1].rt;
        InValid = 1'b1;
        @(posedge Clock); #1;
        InValid = 1'b0;
        repeat (20) @(posedge Clock);
        #1;
        chk("pre_abort busy", 64'(Busy), 64'd1);
        Reset = 1'b1;
        #1;
        chk("abort busy", 64'(Busy), 64'd0);
        chk("abort valid", 64'(ValidOut), 64'd0);
        chk("abort out", 64'(OutputDegrees), 64'd0);
        #1;
        Reset = 1'b0;
        vo_seen = 0;
        for (int n = 0; n < 60; n++) begin
            @(posedge Clock); #1;
            if (ValidOut) vo_seen++;
        end
        chk("abort no_valid", 64'(vo_seen), 64'd0);
        run_vec(vecs[5]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
